// File: rtl/seven_seg_monitor.sv
// Receive-side checker for a 3-bit up/down counter display: decodes the sampled
// 7-segment pattern, cross-checks it against the LED word and tracks legal steps.
module seven_seg_monitor (
  input  logic       clock,
  input  logic       reset,
  input  logic       HIGH,
  input  logic       LOW,
  input  logic       strobe,
  input  logic       down,
  input  logic       in,
  input  logic [6:0] seg,
  input  logic [2:0] led,
  input  logic       clear,
  output logic [2:0] value,
  output logic       valid,
  output logic       mismatch,
  output logic       step_err,
  output logic       code_err,
  output logic       err_flag,
  output logic [7:0] err_count
);

  typedef enum logic {ACQ, TRACK} state_t;

  state_t     state;
  logic       legal;
  logic [2:0] decoded;
  logic [2:0] expected;
  logic       sample_mismatch;
  logic       sample_step_err;
  logic       sample_err;

  // The constant tie-off pins carry no information the checker needs.
  logic unused_ties;
  assign unused_ties = HIGH ^ LOW;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    legal   = 1'b1;
    decoded = 3'd0;
    case (seg)
      7'h3F:   decoded = 3'd0;
      7'h06:   decoded = 3'd1;
      7'h5B:   decoded = 3'd2;
      7'h4F:   decoded = 3'd3;
      7'h66:   decoded = 3'd4;
      7'h6D:   decoded = 3'd5;
      7'h7D:   decoded = 3'd6;
      7'h07:   decoded = 3'd7;
      default: legal   = 1'b0;
    endcase
  end

  // Reload wins over direction; the 3-bit arithmetic provides the mod-8 wrap.
  always_comb begin
    expected = value + 3'd1;
    if (!in)       expected = 3'd4;
    else if (down) expected = value - 3'd1;
  end

  assign sample_mismatch = legal && (decoded != led);
  assign sample_step_err = legal && (state == TRACK) && (decoded != expected);
  assign sample_err      = !legal || sample_mismatch || sample_step_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ACQ;
      value    <= 3'd0;
      valid    <= 1'b0;
      mismatch <= 1'b0;
      step_err <= 1'b0;
      code_err <= 1'b0;
    end else if (strobe) begin
      mismatch <= sample_mismatch;
      step_err <= sample_step_err;
      code_err <= !legal;
      if (legal) begin
        state <= TRACK;
        valid <= 1'b1;
        value <= decoded;
      end else begin
        state <= ACQ;
        valid <= 1'b0;
      end
    end
  end

  // Clear has priority over an error reported on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end else if (clear) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end else if (strobe && sample_err) begin
      err_flag <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_seven_seg_monitor.sv
// Directed, table-driven bench for seven_seg_monitor with hand-computed
// expectations plus sequences for reset, saturation and clear priority.
module tb_seven_seg_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic       HIGH = 1'b1;
  logic       LOW  = 1'b0;
  logic       strobe, down, in, clear;
  logic [6:0] seg;
  logic [2:0] led;
  logic [2:0] value;
  logic       valid, mismatch, step_err, code_err, err_flag;
  logic [7:0] err_count;

  int n_vec = 0;
  int n_bad = 0;

  seven_seg_monitor dut (
    .clock(clock), .reset(reset), .HIGH(HIGH), .LOW(LOW),
    .strobe(strobe), .down(down), .in(in), .seg(seg), .led(led), .clear(clear),
    .value(value), .valid(valid), .mismatch(mismatch), .step_err(step_err),
    .code_err(code_err), .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       stb;
    logic       dn;
    logic       ld_n;
    logic [6:0] sg;
    logic [2:0] ld;
    logic       clr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[20];

  // Expected output word: {value, valid, mismatch, step_err, code_err, err_flag, err_count}.
  function automatic logic [15:0] pk(input logic [2:0] v, input logic vl, input logic mm,
                                     input logic se, input logic ce, input logic ef,
                                     input logic [7:0] cnt);
    return {v, vl, mm, se, ce, ef, cnt};
  endfunction

  function automatic logic [15:0] observed();
    return {value, valid, mismatch, step_err, code_err, err_flag, err_count};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got value=%0d valid=%b mm=%b se=%b ce=%b ef=%b cnt=%0d, want value=%0d valid=%b mm=%b se=%b ce=%b ef=%b cnt=%0d",
               name, act[15:13], act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[15:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Drive one cycle of inputs just after an edge, let the next edge sample them.
  task automatic step(input logic stb, input logic dn, input logic ld_n,
                      input logic [6:0] sg, input logic [2:0] ld, input logic clr);
    strobe = stb; down = dn; in = ld_n; seg = sg; led = ld; clear = clr;
    @(posedge clock);
    #1;
    strobe = 1'b0;
    clear  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 7'h66, 3'd4, 1'b0, pk(3'd4, 1, 0, 0, 0, 0, 8'd0)};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 7'h6D, 3'd5, 1'b0, pk(3'd5, 1, 0, 0, 0, 0, 8'd0)};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 7'h7D, 3'd6, 1'b0, pk(3'd6, 1, 0, 0, 0, 0, 8'd0)};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 7'h07, 3'd7, 1'b0, pk(3'd7, 1, 0, 0, 0, 0, 8'd0)};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 7'h3F, 3'd0, 1'b0, pk(3'd0, 1, 0, 0, 0, 0, 8'd0)};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 7'h7D, 3'd6, 1'b0, pk(3'd6, 1, 0, 1, 0, 1, 8'd1)};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 7'h6D, 3'd5, 1'b0, pk(3'd5, 1, 0, 0, 0, 1, 8'd1)};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 7'h66, 3'd4, 1'b0, pk(3'd4, 1, 0, 0, 0, 1, 8'd1)};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 7'h4F, 3'd3, 1'b0, pk(3'd3, 1, 0, 0, 0, 1, 8'd1)};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 7'h5B, 3'd2, 1'b0, pk(3'd2, 1, 0, 0, 0, 1, 8'd1)};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 7'h66, 3'd4, 1'b0, pk(3'd4, 1, 0, 0, 0, 1, 8'd1)};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 7'h5B, 3'd3, 1'b0, pk(3'd2, 1, 1, 1, 0, 1, 8'd2)};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 7'h7F, 3'd2, 1'b0, pk(3'd2, 1, 1, 1, 0, 1, 8'd2)};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 7'h7F, 3'd2, 1'b0, pk(3'd2, 0, 0, 0, 1, 1, 8'd3)};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 7'h3F, 3'd0, 1'b0, pk(3'd0, 1, 0, 0, 0, 1, 8'd3)};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 7'h06, 3'd1, 1'b0, pk(3'd1, 1, 0, 0, 0, 1, 8'd3)};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 7'h3F, 3'd0, 1'b0, pk(3'd0, 1, 0, 0, 0, 1, 8'd3)};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 7'h07, 3'd7, 1'b0, pk(3'd7, 1, 0, 0, 0, 1, 8'd3)};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 7'h00, 3'd0, 1'b1, pk(3'd7, 1, 0, 0, 0, 0, 8'd0)};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 7'h3F, 3'd0, 1'b0, pk(3'd0, 1, 0, 0, 0, 0, 8'd0)};

    reset = 1'b0; strobe = 1'b0; down = 1'b0; in = 1'b1; clear = 1'b0;
    seg = 7'h00; led = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", observed(), pk(3'd0, 0, 0, 0, 0, 0, 8'd0));
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].stb, vecs[i].dn, vecs[i].ld_n, vecs[i].sg, vecs[i].ld, vecs[i].clr);
      check($sformatf("vec%0d", i), observed(), vecs[i].exp);
    end

    // Build up an error, then reset asynchronously between edges.
    step(1'b1, 1'b0, 1'b1, 7'h5B, 3'd2, 1'b0);
    check("pre_reset_err", observed(), pk(3'd2, 1, 0, 1, 0, 1, 8'd1));
    #2 reset = 1'b0;
    #1;
    check("async_reset", observed(), pk(3'd0, 0, 0, 0, 0, 0, 8'd0));
    @(posedge clock);
    #1 reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 7'h4F, 3'd3, 1'b0);
    check("first_after_reset", observed(), pk(3'd3, 1, 0, 0, 0, 0, 8'd0));

    // Saturation: 260 consecutive illegal-code samples.
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, 1'b1, 7'h00, 3'd0, 1'b0);
      if (i == 253) check("count_254", observed(), pk(3'd3, 0, 0, 0, 1, 1, 8'd254));
      if (i == 254) check("count_255", observed(), pk(3'd3, 0, 0, 0, 1, 1, 8'd255));
    end
    check("count_saturated", observed(), pk(3'd3, 0, 0, 0, 1, 1, 8'd255));

    step(1'b1, 1'b0, 1'b1, 7'h00, 3'd0, 1'b1);
    check("clear_beats_error", observed(), pk(3'd3, 0, 0, 0, 1, 0, 8'd0));
    step(1'b1, 1'b0, 1'b1, 7'h00, 3'd0, 1'b0);
    check("count_after_clear", observed(), pk(3'd3, 0, 0, 0, 1, 1, 8'd1));
    step(1'b1, 1'b0, 1'b1, 7'h7D, 3'd6, 1'b0);
    check("relock", observed(), pk(3'd6, 1, 0, 0, 0, 1, 8'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
